// File: rtl/div_pkg.sv
// Shared definitions for the iterative RV64M divide unit: op codes, FSM states,
// and the word-result sign-extension helper.
package div_pkg;
   localparam int XLEN  = 64;
   localparam int CNT_W = 7;

   localparam logic [1:0] DIV_OP_DIV  = 2'b00;
   localparam logic [1:0] DIV_OP_DIVU = 2'b01;
   localparam logic [1:0] DIV_OP_REM  = 2'b10;
   localparam logic [1:0] DIV_OP_REMU = 2'b11;

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} div_state_e;

   function automatic logic [XLEN-1:0] sext_w(input logic [XLEN-1:0] v);
      return {{(XLEN-32){v[31]}}, v[31:0]};
   endfunction
endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: trial subtract of the divisor magnitude
// from the shifted partial remainder; the quotient bit is the inverted sign.
module div_step #(
   parameter int XLEN = 64
) (
   input  logic [XLEN:0]   r_shift,
   input  logic [XLEN-1:0] b_mag,
   output logic [XLEN:0]   r_next,
   output logic            q_bit
);
   logic [XLEN:0] t;

   always_comb begin
      t      = r_shift - {1'b0, b_mag};
      q_bit  = ~t[XLEN];
      r_next = q_bit ? t : r_shift;
   end
endmodule

// File: rtl/div_iter_ctrl.sv
// RV64M divide/remainder unit: operand prep at accept, 1 bit/cycle restoring
// division, sign fix-up, then hold the result until writeback takes it.
module div_iter_ctrl #(
   parameter int XLEN  = 64,
   parameter int CNT_W = 7
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [1:0]      op,
   input  logic            is_word,
   input  logic [XLEN-1:0] dividend,
   input  logic [XLEN-1:0] divisor,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result
);
   import div_pkg::*;

   div_state_e      state_q, state_d;
   logic [CNT_W-1:0] count;
   logic [XLEN-1:0] q_reg, b_mag, result_q;
   logic [XLEN:0]   r_reg;
   logic            sign_a, sign_b, signed_r, rem_r, word_r, out_valid_q;

   logic            signed_in, accept, b_zero, sa_in, sb_in, last_iter;
   logic [XLEN-1:0] a_prep, b_prep, a_mag, b_mag_in, dz_res;
   logic [XLEN-1:0] q_fix, r_fix, sel_res, fix_res;
   logic [XLEN:0]   r_shift, r_next;
   logic            q_bit;

   assign in_ready  = (state_q == IDLE);
   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign accept    = in_valid & in_ready & ~flush;
   assign last_iter = (count == CNT_W'(XLEN-1));

   // Operand prep: word ops narrow to 32 bits first, then signed ops go to magnitudes.
   always_comb begin
      signed_in = ~op[0];
      a_prep    = dividend;
      b_prep    = divisor;
      if (is_word) begin
         a_prep = signed_in ? sext_w(dividend) : {{(XLEN-32){1'b0}}, dividend[31:0]};
         b_prep = signed_in ? sext_w(divisor)  : {{(XLEN-32){1'b0}}, divisor[31:0]};
      end
      sa_in    = signed_in & a_prep[XLEN-1];
      sb_in    = signed_in & b_prep[XLEN-1];
      a_mag    = sa_in ? -a_prep : a_prep;
      b_mag_in = sb_in ? -b_prep : b_prep;
      b_zero   = (b_prep == '0);
      dz_res   = op[1] ? (is_word ? sext_w(a_prep) : a_prep) : '1;
   end

   assign r_shift = {r_reg[XLEN-1:0], q_reg[XLEN-1]};

   div_step #(.XLEN(XLEN)) u_step (
      .r_shift (r_shift),
      .b_mag   (b_mag),
      .r_next  (r_next),
      .q_bit   (q_bit)
   );

   always_comb begin
      q_fix   = (signed_r & (sign_a ^ sign_b)) ? -q_reg : q_reg;
      r_fix   = (signed_r & sign_a) ? -r_reg[XLEN-1:0] : r_reg[XLEN-1:0];
      sel_res = rem_r ? r_fix : q_fix;
      fix_res = word_r ? sext_w(sel_res) : sel_res;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (accept) state_d = b_zero ? DONE : CALC;
         CALC: if (last_iter) state_d = FIX;
         FIX:  state_d = DONE;
         DONE: if (out_valid_q & out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (flush) state_d = IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count       <= '0;
         q_reg       <= '0;
         r_reg       <= '0;
         b_mag       <= '0;
         sign_a      <= 1'b0;
         sign_b      <= 1'b0;
         signed_r    <= 1'b0;
         rem_r       <= 1'b0;
         word_r      <= 1'b0;
         result_q    <= '0;
         out_valid_q <= 1'b0;
      end else if (flush) begin
         count       <= '0;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (accept) begin
               sign_a   <= sa_in;
               sign_b   <= sb_in;
               signed_r <= signed_in;
               rem_r    <= op[1];
               word_r   <= is_word;
               b_mag    <= b_mag_in;
               q_reg    <= a_mag;
               r_reg    <= '0;
               count    <= '0;
               if (b_zero) begin
                  result_q    <= dz_res;
                  out_valid_q <= 1'b1;
               end
            end
            CALC: begin
               q_reg <= {q_reg[XLEN-2:0], q_bit};
               r_reg <= r_next;
               if (!last_iter) count <= count + 1'b1;
            end
            FIX: begin
               result_q    <= fix_res;
               out_valid_q <= 1'b1;
            end
            DONE: if (out_ready) out_valid_q <= 1'b0;
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_div_iter_ctrl.sv
// Directed bench for div_iter_ctrl: results, latency, special cases,
// backpressure, flush and mid-op reset.
module tb_div_iter_ctrl;
   logic        clk = 1'b0;
   logic        rst, flush, in_valid, in_ready, is_word, out_valid, out_ready;
   logic [1:0]  op;
   logic [63:0] dividend, divisor, result;
   int          errs = 0;
   int          checks = 0;

   always #5 clk = ~clk;

   div_iter_ctrl dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .is_word(is_word), .dividend(dividend), .divisor(divisor),
      .out_valid(out_valid), .out_ready(out_ready), .result(result)
   );

   // Drive one request; returns at the negedge after the accept edge.
   task automatic issue(input logic [1:0] o, input logic w, input logic [63:0] a, input logic [63:0] b);
      @(negedge clk);
      op = o; is_word = w; dividend = a; divisor = b; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0; dividend = ~a; divisor = ~b; op = ~o; is_word = ~w;
   endtask

   // lat counts rising edges with the accept edge as edge 1.
   task automatic wait_valid(output int lat);
      lat = 1;
      while (!out_valid && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      if (!out_valid) begin
         checks++; errs++;
         $display("FAIL wait_valid timeout: out_valid=%b after %0d edges, required 1", out_valid, lat);
      end
   endtask

   task automatic handshake();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic run_op(input string name, input logic [1:0] o, input logic w,
                         input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] exp, input int exp_lat);
      int lat;
      issue(o, w, a, b);
      wait_valid(lat);
      checks++;
      if (result !== exp) begin
         errs++;
         $display("FAIL %s result: got %h, required %h", name, result, exp);
      end
      if (exp_lat > 0) begin
         checks++;
         if (lat !== exp_lat) begin
            errs++;
            $display("FAIL %s latency: got %0d, required %0d", name, lat, exp_lat);
         end
      end
      handshake();
   endtask

   task automatic test_reset();
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      op = 2'b00; is_word = 1'b0; dividend = '0; divisor = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      checks += 3;
      if (out_valid !== 1'b0) begin errs++; $display("FAIL reset out_valid: got %b, required 0", out_valid); end
      if (result !== 64'h0)   begin errs++; $display("FAIL reset result: got %h, required 0", result); end
      if (in_ready !== 1'b1)  begin errs++; $display("FAIL reset in_ready: got %b, required 1", in_ready); end
   endtask

   task automatic test_signed();
      run_op("div_m7_2", 2'b00, 1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 66);
      run_op("rem_m7_2", 2'b10, 1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66);
   endtask

   task automatic test_div_zero();
      run_op("divu_123_0", 2'b01, 1'b0, 64'd123, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
      run_op("rem_m5_0",   2'b10, 1'b0, -64'sd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFB, 1);
   endtask

   task automatic test_overflow();
      run_op("div_ovf", 2'b00, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 0);
      run_op("rem_ovf", 2'b10, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 0);
   endtask

   task automatic test_word();
      run_op("divw",  2'b00, 1'b1, 64'h1234_5678_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 66);
      run_op("divuw", 2'b01, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 0);
      run_op("remuw", 2'b11, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'h10, 64'hF, 0);
   endtask

   task automatic test_backpressure();
      int lat;
      logic stable;
      issue(2'b01, 1'b0, 64'd100, 64'd7);
      wait_valid(lat);
      stable = 1'b1;
      repeat (10) begin
         @(negedge clk);
         if (out_valid !== 1'b1 || result !== 64'd14 || in_ready !== 1'b0) stable = 1'b0;
      end
      checks++;
      if (stable !== 1'b1) begin
         errs++;
         $display("FAIL backpressure hold: out_valid=%b result=%h in_ready=%b, required 1/%h/0", out_valid, result, in_ready, 64'd14);
      end
      handshake();
      checks += 2;
      if (out_valid !== 1'b0) begin errs++; $display("FAIL backpressure release out_valid: got %b, required 0", out_valid); end
      if (in_ready !== 1'b1)  begin errs++; $display("FAIL backpressure release in_ready: got %b, required 1", in_ready); end
   endtask

   task automatic test_flush();
      issue(2'b00, 1'b0, 64'd1000, 64'd3);
      repeat (30) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      checks += 2;
      if (out_valid !== 1'b0) begin errs++; $display("FAIL flush out_valid: got %b, required 0", out_valid); end
      if (in_ready !== 1'b1)  begin errs++; $display("FAIL flush in_ready: got %b, required 1", in_ready); end
      run_op("divu_after_flush", 2'b01, 1'b0, 64'd100, 64'd7, 64'd14, 66);
      // flush in IDLE must block a concurrent request
      @(negedge clk);
      flush = 1'b1; in_valid = 1'b1; op = 2'b01; is_word = 1'b0; dividend = 64'd9; divisor = 64'd0;
      @(negedge clk);
      flush = 1'b0; in_valid = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errs++;
         $display("FAIL flush_idle_block: in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
      end
   endtask

   task automatic test_mid_reset();
      logic spurious;
      issue(2'b01, 1'b0, 64'd500, 64'd9);
      repeat (10) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks += 3;
      if (out_valid !== 1'b0) begin errs++; $display("FAIL midrst out_valid: got %b, required 0", out_valid); end
      if (result !== 64'h0)   begin errs++; $display("FAIL midrst result: got %h, required 0", result); end
      if (in_ready !== 1'b1)  begin errs++; $display("FAIL midrst in_ready: got %b, required 1", in_ready); end
      spurious = 1'b0;
      repeat (80) begin
         @(negedge clk);
         if (out_valid !== 1'b0) spurious = 1'b1;
      end
      checks++;
      if (spurious !== 1'b0) begin errs++; $display("FAIL midrst spurious out_valid: got %b, required 0", spurious); end
   endtask

   initial begin
      test_reset();
      test_signed();
      test_div_zero();
      test_overflow();
      test_word();
      test_backpressure();
      test_flush();
      test_mid_reset();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
